ace_rd_arbiter: RTL and testbench

//  Shares one ACE read path (AR/R/RACK) to lower-level memory between two read requesters:

---
 rtl/ace_rd_arbiter_if.sv | 29 ++
 rtl/ace_rd_arbiter.sv | 136 +++++++++++++
 tb/tb_ace_rd_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_rd_arbiter_if.sv
// ACE read channel bundle (AR, R and RACK) shared by the requester and downstream sides.
// "master" issues read requests, "slave" accepts them and returns R beats.
interface ace_rd_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [3:0]            rresp;
  logic                  rlast;
  logic                  rack;

  modport master (
    output arvalid, araddr, arlen, arsize, arburst, rready, rack,
    input  arready, rvalid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, araddr, arlen, arsize, arburst, rready, rack,
    output arready, rvalid, rdata, rresp, rlast
  );
endinterface

// File: rtl/ace_rd_arbiter.sv
// Round-robin arbiter sharing one downstream ACE read path between IFU (s0) and LSU (s1).
// A single transaction is in flight at a time; R beats are steered back to the granted port.
module ace_rd_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  ace_rd_arbiter_if.slave        s0,
  ace_rd_arbiter_if.slave        s1,
  ace_rd_arbiter_if.master       m,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  grant_q, grant_d;
  logic                  prio_q, prio_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rack_win_q, rack_win_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;

  logic                  grant;
  logic                  s0_arready, s1_arready;
  logic                  s0_rvalid, s1_rvalid;
  logic                  m_rready, m_rack;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    prio_d     = prio_q;
    arvalid_d  = arvalid_q;
    rack_win_d = 1'b0;
    araddr_d   = araddr_q;
    arlen_d    = arlen_q;
    arsize_d   = arsize_q;
    arburst_d  = arburst_q;
    s0_arready = 1'b0;
    s1_arready = 1'b0;
    s0_rvalid  = 1'b0;
    s1_rvalid  = 1'b0;
    m_rready   = 1'b0;
    m_rack     = 1'b0;
    grant      = (s0.arvalid && s1.arvalid) ? prio_q : s1.arvalid;

    unique case (state_q)
      IDLE: begin
        // rack window stays open one cycle so a late acknowledge still reaches downstream
        m_rack = rack_win_q & (grant_q ? s1.rack : s0.rack);
        if (s0.arvalid || s1.arvalid) begin
          s0_arready = ~grant;
          s1_arready = grant;
          araddr_d   = grant ? s1.araddr  : s0.araddr;
          arlen_d    = grant ? s1.arlen   : s0.arlen;
          arsize_d   = grant ? s1.arsize  : s0.arsize;
          arburst_d  = grant ? s1.arburst : s0.arburst;
          grant_d    = grant;
          prio_d     = ~grant;
          arvalid_d  = 1'b1;
          state_d    = ADDR;
        end
      end
      ADDR: begin
        if (m.arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end
      DATA: begin
        s0_rvalid = ~grant_q & m.rvalid;
        s1_rvalid =  grant_q & m.rvalid;
        m_rready  = grant_q ? s1.rready : s0.rready;
        m_rack    = grant_q ? s1.rack   : s0.rack;
        if (m.rvalid && m_rready && m.rlast) begin
          state_d    = IDLE;
          rack_win_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      prio_q     <= 1'b0;
      arvalid_q  <= 1'b0;
      rack_win_q <= 1'b0;
      araddr_q   <= '0;
      arlen_q    <= '0;
      arsize_q   <= '0;
      arburst_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      prio_q     <= prio_d;
      arvalid_q  <= arvalid_d;
      rack_win_q <= rack_win_d;
      araddr_q   <= araddr_d;
      arlen_q    <= arlen_d;
      arsize_q   <= arsize_d;
      arburst_q  <= arburst_d;
    end
  end

  assign s0.arready = s0_arready;
  assign s1.arready = s1_arready;
  assign s0.rvalid  = s0_rvalid;
  assign s1.rvalid  = s1_rvalid;
  assign s0.rdata   = m.rdata;
  assign s1.rdata   = m.rdata;
  assign s0.rresp   = m.rresp;
  assign s1.rresp   = m.rresp;
  assign s0.rlast   = m.rlast;
  assign s1.rlast   = m.rlast;

  assign m.arvalid  = arvalid_q;
  assign m.araddr   = araddr_q;
  assign m.arlen    = arlen_q;
  assign m.arsize   = arsize_q;
  assign m.arburst  = arburst_q;
  assign m.rready   = m_rready;
  assign m.rack     = m_rack;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// Scenario bench for ace_rd_arbiter: directed cases plus randomized rounds checked against
// a transaction-level round-robin model.
module tb_ace_rd_arbiter;
  localparam int AW = 32;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   total = 0;
  int   bad   = 0;

  ace_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_if ();
  ace_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s1_if ();
  ace_rd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_if ();

  ace_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst  (rst),
    .s0   (s0_if),
    .s1   (s1_if),
    .m    (m_if),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    s0_if.arvalid = 1'b0; s0_if.araddr = '0; s0_if.arlen = '0; s0_if.arsize = '0; s0_if.arburst = '0;
    s0_if.rready = 1'b0; s0_if.rack = 1'b0;
    s1_if.arvalid = 1'b0; s1_if.araddr = '0; s1_if.arlen = '0; s1_if.arsize = '0; s1_if.arburst = '0;
    s1_if.rready = 1'b0; s1_if.rack = 1'b0;
    m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rdata = '0; m_if.rresp = '0; m_if.rlast = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic request(input int port, input logic [AW-1:0] addr, input logic [7:0] len);
    if (port == 0) begin
      s0_if.arvalid = 1'b1; s0_if.araddr = addr; s0_if.arlen = len; s0_if.arsize = 3'd4; s0_if.arburst = 2'b01;
    end else begin
      s1_if.arvalid = 1'b1; s1_if.araddr = addr; s1_if.arlen = len; s1_if.arsize = 3'd4; s1_if.arburst = 2'b01;
    end
  endtask

  task automatic drop_req(input int port);
    if (port == 0) s0_if.arvalid = 1'b0;
    else           s1_if.arvalid = 1'b0;
  endtask

  task automatic set_rready(input int port, input logic v);
    if (port == 0) s0_if.rready = v;
    else           s1_if.rready = v;
  endtask

  task automatic set_rack(input int port, input logic v);
    if (port == 0) s0_if.rack = v;
    else           s1_if.rack = v;
  endtask

  // Called in the ADDR cycle; completes the AR handshake and delivers all beats without stalls.
  task automatic finish_txn(input int port, input int beats);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    for (int i = 0; i < beats; i++) begin
      m_if.rvalid = 1'b1;
      m_if.rlast  = (i == beats - 1);
      m_if.rdata  = {$urandom, $urandom, $urandom, $urandom};
      set_rready(port, 1'b1);
      tick();
    end
    m_if.rvalid = 1'b0;
    m_if.rlast  = 1'b0;
    s0_if.rready = 1'b0;
    s1_if.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    total++; if (m_if.arvalid !== 1'b0) begin bad++; $display("[TB] FAIL reset_arvalid got=%0b exp=0", m_if.arvalid); end
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b00) begin bad++; $display("[TB] FAIL reset_arready got=%0b exp=00", {s1_if.arready, s0_if.arready}); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (m_if.rready !== 1'b0) begin bad++; $display("[TB] FAIL reset_rready got=%0b exp=0", m_if.rready); end
    total++; if (m_if.araddr !== '0) begin bad++; $display("[TB] FAIL reset_araddr got=%0h exp=0", m_if.araddr); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    logic [DW-1:0] dead;
    dead = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    do_reset();
    request(0, 32'h0000_1000, 8'd0);
    #1;
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b01) begin bad++; $display("[TB] FAIL single_grant got=%0b exp=01", {s1_if.arready, s0_if.arready}); end
    total++; if (m_if.arvalid !== 1'b0) begin bad++; $display("[TB] FAIL single_arvalid_early got=%0b exp=0", m_if.arvalid); end
    tick();
    drop_req(0);
    #1;
    total++; if (m_if.arvalid !== 1'b1) begin bad++; $display("[TB] FAIL single_arvalid got=%0b exp=1", m_if.arvalid); end
    total++; if (m_if.araddr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL single_araddr got=%0h exp=1000", m_if.araddr); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%0b exp=1", busy); end
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata = dead; s0_if.rready = 1'b1;
    #1;
    total++; if ({s1_if.rvalid, s0_if.rvalid} !== 2'b01) begin bad++; $display("[TB] FAIL single_rvalid got=%0b exp=01", {s1_if.rvalid, s0_if.rvalid}); end
    total++; if (s0_if.rdata !== dead) begin bad++; $display("[TB] FAIL single_rdata got=%0h exp=%0h", s0_if.rdata, dead); end
    total++; if (m_if.rready !== 1'b1) begin bad++; $display("[TB] FAIL single_rready got=%0b exp=1", m_if.rready); end
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s0_if.rready = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_idle got=%0b exp=0", busy); end
  endtask

  task automatic test_contention();
    do_reset();
    request(0, 32'h0000_1000, 8'd0);
    request(1, 32'h0000_2000, 8'd0);
    #1;
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b01) begin bad++; $display("[TB] FAIL cont_first got=%0b exp=01", {s1_if.arready, s0_if.arready}); end
    tick();
    drop_req(0);
    #1;
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b00) begin bad++; $display("[TB] FAIL cont_holdoff got=%0b exp=00", {s1_if.arready, s0_if.arready}); end
    total++; if (m_if.araddr !== 32'h0000_1000) begin bad++; $display("[TB] FAIL cont_addr0 got=%0h exp=1000", m_if.araddr); end
    finish_txn(0, 1);
    #1;
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b10) begin bad++; $display("[TB] FAIL cont_second got=%0b exp=10", {s1_if.arready, s0_if.arready}); end
    tick();
    drop_req(1);
    #1;
    total++; if (m_if.araddr !== 32'h0000_2000) begin bad++; $display("[TB] FAIL cont_addr1 got=%0h exp=2000", m_if.araddr); end
    finish_txn(1, 1);
    request(0, 32'h0000_1100, 8'd0);
    request(1, 32'h0000_2100, 8'd0);
    #1;
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b01) begin bad++; $display("[TB] FAIL cont_third got=%0b exp=01", {s1_if.arready, s0_if.arready}); end
    tick();
    drop_req(0);
    drop_req(1);
    finish_txn(0, 1);
  endtask

  task automatic test_backpressure();
    do_reset();
    request(1, 32'h0000_3000, 8'd0);
    #1;
    tick();
    drop_req(1);
    for (int i = 0; i < 5; i++) begin
      #1;
      total++; if ({m_if.arvalid, m_if.araddr, m_if.arsize} !== {1'b1, 32'h0000_3000, 3'd4}) begin
        bad++; $display("[TB] FAIL bp_ar_stable cyc=%0d got=%0b/%0h/%0d exp=1/3000/4", i, m_if.arvalid, m_if.araddr, m_if.arsize);
      end
      tick();
    end
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1; m_if.rdata = 128'h3;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({m_if.rready, s1_if.rvalid, busy} !== 3'b011) begin
        bad++; $display("[TB] FAIL bp_rhold cyc=%0d got=%0b exp=011", i, {m_if.rready, s1_if.rvalid, busy});
      end
      tick();
    end
    s1_if.rready = 1'b1;
    #1;
    total++; if (m_if.rready !== 1'b1) begin bad++; $display("[TB] FAIL bp_release got=%0b exp=1", m_if.rready); end
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s1_if.rready = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL bp_done got=%0b exp=0", busy); end
  endtask

  task automatic test_burst();
    logic [DW-1:0] d;
    do_reset();
    request(1, 32'h0000_4000, 8'd3);
    #1;
    tick();
    drop_req(1);
    #1;
    total++; if (m_if.arlen !== 8'd3) begin bad++; $display("[TB] FAIL burst_arlen got=%0d exp=3", m_if.arlen); end
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m_if.rvalid = 1'b1; m_if.rlast = (b == 3); m_if.rdata = d; s1_if.rready = 1'b1;
      #1;
      total++; if ({s1_if.rvalid, s0_if.rvalid, busy} !== 3'b101) begin
        bad++; $display("[TB] FAIL burst_route beat=%0d got=%0b exp=101", b, {s1_if.rvalid, s0_if.rvalid, busy});
      end
      total++; if (s1_if.rdata !== d) begin bad++; $display("[TB] FAIL burst_data beat=%0d got=%0h exp=%0h", b, s1_if.rdata, d); end
      tick();
    end
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s1_if.rready = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL burst_exit got=%0b exp=0", busy); end
  endtask

  task automatic test_rack_reset();
    do_reset();
    request(0, 32'h0000_5000, 8'd0);
    #1;
    tick();
    drop_req(0);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    s1_if.rack = 1'b1;
    #1;
    total++; if (m_if.rack !== 1'b0) begin bad++; $display("[TB] FAIL rack_data_other got=%0b exp=0", m_if.rack); end
    s1_if.rack = 1'b0; s0_if.rack = 1'b1;
    #1;
    total++; if (m_if.rack !== 1'b1) begin bad++; $display("[TB] FAIL rack_data_own got=%0b exp=1", m_if.rack); end
    s0_if.rack = 1'b0;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b1; s0_if.rready = 1'b1;
    tick();
    m_if.rvalid = 1'b0; m_if.rlast = 1'b0; s0_if.rready = 1'b0;
    s0_if.rack = 1'b1;
    #1;
    total++; if (m_if.rack !== 1'b1) begin bad++; $display("[TB] FAIL rack_late got=%0b exp=1", m_if.rack); end
    s0_if.rack = 1'b0; s1_if.rack = 1'b1;
    #1;
    total++; if (m_if.rack !== 1'b0) begin bad++; $display("[TB] FAIL rack_late_other got=%0b exp=0", m_if.rack); end
    s1_if.rack = 1'b0;
    tick();
    s0_if.rack = 1'b1;
    #1;
    total++; if (m_if.rack !== 1'b0) begin bad++; $display("[TB] FAIL rack_window_closed got=%0b exp=0", m_if.rack); end
    s0_if.rack = 1'b0;
    tick();

    // Abandon a burst mid-DATA with reset, then confirm the arbiter grants normally again.
    request(1, 32'h0000_6000, 8'd1);
    #1;
    tick();
    drop_req(1);
    m_if.arready = 1'b1;
    tick();
    m_if.arready = 1'b0;
    m_if.rvalid = 1'b1; m_if.rlast = 1'b0; s1_if.rready = 1'b1;
    #1;
    total++; if (m_if.rready !== 1'b1) begin bad++; $display("[TB] FAIL rst_pre_rready got=%0b exp=1", m_if.rready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if ({busy, m_if.rready, s1_if.rvalid, m_if.arvalid} !== 4'b0000) begin
      bad++; $display("[TB] FAIL rst_mid_data got=%0b exp=0000", {busy, m_if.rready, s1_if.rvalid, m_if.arvalid});
    end
    m_if.rvalid = 1'b0; s1_if.rready = 1'b0;
    tick();
    request(1, 32'h0000_7000, 8'd0);
    #1;
    total++; if ({s1_if.arready, s0_if.arready} !== 2'b10) begin bad++; $display("[TB] FAIL rst_regrant got=%0b exp=10", {s1_if.arready, s0_if.arready}); end
    tick();
    drop_req(1);
    #1;
    total++; if ({m_if.arvalid, m_if.araddr} !== {1'b1, 32'h0000_7000}) begin
      bad++; $display("[TB] FAIL rst_regrant_addr got=%0b/%0h exp=1/7000", m_if.arvalid, m_if.araddr);
    end
    finish_txn(1, 1);
  endtask

  // Model: an idle arbiter grants the lone requester, or the favoured one when both ask;
  // the favoured port becomes the one not just granted.
  task automatic test_random();
    logic          pend [2];
    logic [AW-1:0] addr [2];
    logic [7:0]    len  [2];
    logic          prio;
    int            g;
    int            beats;
    int            stall;
    logic          ra;
    logic [DW-1:0] d;
    logic [DW-1:0] got;
    do_reset();
    prio = 1'b0;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int r = 0; r < 40; r++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1'b1; addr[p] = $urandom & 32'hFFFF_FFC0; len[p] = 8'($urandom_range(0, 3));
          request(p, addr[p], len[p]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        g = $urandom_range(0, 1);
        pend[g] = 1'b1; addr[g] = $urandom & 32'hFFFF_FFC0; len[g] = 8'($urandom_range(0, 3));
        request(g, addr[g], len[g]);
      end
      g = (pend[0] && pend[1]) ? int'(prio) : (pend[1] ? 1 : 0);
      prio = (g == 0);
      #1;
      total++; if ({s1_if.arready, s0_if.arready} !== ((g == 1) ? 2'b10 : 2'b01)) begin
        bad++; $display("[TB] FAIL rnd_grant round=%0d got=%0b exp_port=%0d", r, {s1_if.arready, s0_if.arready}, g);
      end
      tick();
      drop_req(g);
      pend[g] = 1'b0;
      repeat ($urandom_range(0, 3)) tick();
      #1;
      total++; if ({m_if.arvalid, m_if.araddr, m_if.arlen} !== {1'b1, addr[g], len[g]}) begin
        bad++; $display("[TB] FAIL rnd_ar round=%0d got=%0b/%0h/%0d exp=1/%0h/%0d", r, m_if.arvalid, m_if.araddr, m_if.arlen, addr[g], len[g]);
      end
      total++; if ({s1_if.arready, s0_if.arready} !== 2'b00) begin
        bad++; $display("[TB] FAIL rnd_holdoff round=%0d got=%0b exp=00", r, {s1_if.arready, s0_if.arready});
      end
      m_if.arready = 1'b1;
      tick();
      m_if.arready = 1'b0;
      beats = int'(len[g]) + 1;
      for (int b = 0; b < beats; b++) begin
        d = {$urandom, $urandom, $urandom, $urandom};
        m_if.rvalid = 1'b1; m_if.rlast = (b == beats - 1); m_if.rdata = d; m_if.rresp = 4'($urandom);
        set_rready(1 - g, 1'($urandom));
        set_rack(1 - g, 1'($urandom));
        stall = $urandom_range(0, 2);
        for (int k = 0; k < stall; k++) begin
          set_rready(g, 1'b0);
          #1;
          total++; if (m_if.rready !== 1'b0) begin bad++; $display("[TB] FAIL rnd_stall round=%0d got=%0b exp=0", r, m_if.rready); end
          tick();
        end
        ra = (b == beats - 1) ? 1'($urandom) : 1'b0;
        set_rready(g, 1'b1);
        set_rack(g, ra);
        #1;
        got = (g == 1) ? s1_if.rdata : s0_if.rdata;
        total++; if ({s1_if.rvalid, s0_if.rvalid, m_if.rready, busy} !== {((g == 1) ? 2'b10 : 2'b01), 2'b11}) begin
          bad++; $display("[TB] FAIL rnd_route round=%0d beat=%0d got=%0b exp_port=%0d", r, b, {s1_if.rvalid, s0_if.rvalid, m_if.rready, busy}, g);
        end
        total++; if (got !== d) begin bad++; $display("[TB] FAIL rnd_data round=%0d beat=%0d got=%0h exp=%0h", r, b, got, d); end
        total++; if (m_if.rack !== ra) begin bad++; $display("[TB] FAIL rnd_rack round=%0d beat=%0d got=%0b exp=%0b", r, b, m_if.rack, ra); end
        tick();
      end
      m_if.rvalid = 1'b0; m_if.rlast = 1'b0;
      s0_if.rready = 1'b0; s1_if.rready = 1'b0; s0_if.rack = 1'b0; s1_if.rack = 1'b0;
      #1;
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rnd_done round=%0d got=%0b exp=0", r, busy); end
    end
    drop_req(0);
    drop_req(1);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_burst();
    test_rack_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
